// File: rtl/arch_map_table.sv
// Committed (architectural) logical-to-physical register map for a 4-wide retire stage.
// Releases each writing slot's previous mapping to the free list one cycle after commit.

module arch_map_lane #(
  parameter int NUM_LANES = 4,
  parameter int SLOT      = 0,
  parameter int LOG_W     = 5,
  parameter int PHYS_W    = 7
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_LANES-1:0]                wr_i,
  input  logic [NUM_LANES-1:0][LOG_W-1:0]     ldst_i,
  input  logic [NUM_LANES-1:0][PHYS_W-1:0]    pdst_i,
  input  logic [PHYS_W-1:0]                   tbl_old_i,
  output logic                                free_vld_o,
  output logic [PHYS_W-1:0]                   free_reg_o
);

  logic [PHYS_W-1:0] old_d;
  logic              free_vld_q;
  logic [PHYS_W-1:0] free_reg_q;

  // An older slot retiring to the same logical register supersedes the table
  // entry; ascending scan lets the youngest such slot win.
  always_comb begin
    old_d = tbl_old_i;
    for (int j = 0; j < NUM_LANES; j++) begin
      if (j < SLOT && wr_i[j] && (ldst_i[j] == ldst_i[SLOT]))
        old_d = pdst_i[j];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      free_vld_q <= 1'b0;
      free_reg_q <= '0;
    end else begin
      free_vld_q <= wr_i[SLOT];
      free_reg_q <= wr_i[SLOT] ? old_d : '0;
    end
  end

  assign free_vld_o = free_vld_q;
  assign free_reg_o = free_reg_q;

endmodule

module arch_map_table #(
  parameter int LOG_REGS = 32,
  parameter int LOG_W    = 5,
  parameter int PHYS_W   = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              commitValid0_i,
  input  logic              commitValid1_i,
  input  logic              commitValid2_i,
  input  logic              commitValid3_i,
  input  logic              commitDestValid0_i,
  input  logic              commitDestValid1_i,
  input  logic              commitDestValid2_i,
  input  logic              commitDestValid3_i,
  input  logic [LOG_W-1:0]  commitLogDest0_i,
  input  logic [LOG_W-1:0]  commitLogDest1_i,
  input  logic [LOG_W-1:0]  commitLogDest2_i,
  input  logic [LOG_W-1:0]  commitLogDest3_i,
  input  logic [PHYS_W-1:0] commitPhyDest0_i,
  input  logic [PHYS_W-1:0] commitPhyDest1_i,
  input  logic [PHYS_W-1:0] commitPhyDest2_i,
  input  logic [PHYS_W-1:0] commitPhyDest3_i,
  output logic              freeValid0_o,
  output logic              freeValid1_o,
  output logic              freeValid2_o,
  output logic              freeValid3_o,
  output logic [PHYS_W-1:0] freeReg0_o,
  output logic [PHYS_W-1:0] freeReg1_o,
  output logic [PHYS_W-1:0] freeReg2_o,
  output logic [PHYS_W-1:0] freeReg3_o,
  input  logic [LOG_W-1:0]  archReadAddr_i,
  output logic [PHYS_W-1:0] archReadData_o
);

  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0]              wr;
  logic [NUM_LANES-1:0][LOG_W-1:0]   ldst;
  logic [NUM_LANES-1:0][PHYS_W-1:0]  pdst;
  logic [NUM_LANES-1:0][PHYS_W-1:0]  tbl_old;
  logic [NUM_LANES-1:0]              free_vld;
  logic [NUM_LANES-1:0][PHYS_W-1:0]  free_reg;

  logic [LOG_REGS-1:0][PHYS_W-1:0]   table_q, table_d;

  assign wr   = {commitValid3_i & commitDestValid3_i, commitValid2_i & commitDestValid2_i,
                 commitValid1_i & commitDestValid1_i, commitValid0_i & commitDestValid0_i};
  assign ldst = {commitLogDest3_i, commitLogDest2_i, commitLogDest1_i, commitLogDest0_i};
  assign pdst = {commitPhyDest3_i, commitPhyDest2_i, commitPhyDest1_i, commitPhyDest0_i};

  // Slots are applied oldest first so the youngest writer of a register lands last.
  always_comb begin
    table_d = table_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (wr[k]) table_d[ldst[k]] = pdst[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LOG_REGS; i++) table_q[i] <= PHYS_W'(i);
    end else begin
      table_q <= table_d;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      assign tbl_old[g] = table_q[ldst[g]];

      arch_map_lane #(
        .NUM_LANES (NUM_LANES),
        .SLOT      (g),
        .LOG_W     (LOG_W),
        .PHYS_W    (PHYS_W)
      ) u_lane (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_i       (wr),
        .ldst_i     (ldst),
        .pdst_i     (pdst),
        .tbl_old_i  (tbl_old[g]),
        .free_vld_o (free_vld[g]),
        .free_reg_o (free_reg[g])
      );
    end
  endgenerate

  assign freeValid0_o = free_vld[0];
  assign freeValid1_o = free_vld[1];
  assign freeValid2_o = free_vld[2];
  assign freeValid3_o = free_vld[3];
  assign freeReg0_o   = free_reg[0];
  assign freeReg1_o   = free_reg[1];
  assign freeReg2_o   = free_reg[2];
  assign freeReg3_o   = free_reg[3];

  // Committed state only; same-cycle commits are not forwarded.
  assign archReadData_o = table_q[archReadAddr_i];

endmodule

// File: tb/tb_arch_map_table.sv
// Directed bench for arch_map_table: reset map, release selection, table update, async reset.

module tb_arch_map_table;

  logic             clk;
  logic             reset_n;
  logic [3:0]       cv, cdv;
  logic [3:0][4:0]  cl;
  logic [3:0][6:0]  cp;
  logic [3:0]       fv;
  logic [3:0][6:0]  fr;
  logic [4:0]       raddr;
  logic [6:0]       rdata;

  int checks = 0;
  int errors = 0;

  arch_map_table dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .commitValid0_i     (cv[0]),
    .commitValid1_i     (cv[1]),
    .commitValid2_i     (cv[2]),
    .commitValid3_i     (cv[3]),
    .commitDestValid0_i (cdv[0]),
    .commitDestValid1_i (cdv[1]),
    .commitDestValid2_i (cdv[2]),
    .commitDestValid3_i (cdv[3]),
    .commitLogDest0_i   (cl[0]),
    .commitLogDest1_i   (cl[1]),
    .commitLogDest2_i   (cl[2]),
    .commitLogDest3_i   (cl[3]),
    .commitPhyDest0_i   (cp[0]),
    .commitPhyDest1_i   (cp[1]),
    .commitPhyDest2_i   (cp[2]),
    .commitPhyDest3_i   (cp[3]),
    .freeValid0_o       (fv[0]),
    .freeValid1_o       (fv[1]),
    .freeValid2_o       (fv[2]),
    .freeValid3_o       (fv[3]),
    .freeReg0_o         (fr[0]),
    .freeReg1_o         (fr[1]),
    .freeReg2_o         (fr[2]),
    .freeReg3_o         (fr[3]),
    .archReadAddr_i     (raddr),
    .archReadData_o     (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    cv = '0; cdv = '0; cl = '0; cp = '0;
  endtask

  task automatic set_slot(input int k, input logic v, input logic dv, input int l, input int p);
    cv[k] = v; cdv[k] = dv; cl[k] = 5'(l); cp[k] = 7'(p);
  endtask

  // Let one edge capture the staged commit, then drop the inputs.
  task automatic step();
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic read_check(input string name, input int addr, input int exp);
    raddr = 5'(addr); #1;
    checks++;
    if (rdata !== 7'(exp)) begin
      errors++;
      $display("FAIL %s: read[%0d] got %0d expected %0d", name, addr, rdata, exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    raddr = '0;
    #12;
    raddr = 5'd7; #1;
    checks++;
    if (rdata !== 7'd7) begin errors++; $display("FAIL reset_read7: got %0d expected 7", rdata); end
    checks++;
    if (fv !== 4'b0000) begin errors++; $display("FAIL reset_fv: got %b expected 0000", fv); end
    checks++;
    if (fr !== '0) begin errors++; $display("FAIL reset_fr: got %h expected 0", fr); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk); set_slot(0, 1, 1, 3, 40);
    step();
    checks++;
    if (fv !== 4'b0001) begin errors++; $display("FAIL single_fv: got %b expected 0001", fv); end
    checks++;
    if (fr[0] !== 7'd3) begin errors++; $display("FAIL single_fr0: got %0d expected 3", fr[0]); end
    checks++;
    if (fr[3:1] !== '0) begin errors++; $display("FAIL single_fr_idle: got %h expected 0", fr[3:1]); end
    read_check("single_table3", 3, 40);
  endtask

  task automatic test_same_dest();
    @(negedge clk);
    set_slot(0, 1, 1, 5, 50);
    set_slot(2, 1, 1, 5, 60);
    set_slot(3, 1, 1, 5, 70);
    step();
    checks++;
    if (fv !== 4'b1101) begin errors++; $display("FAIL same_fv: got %b expected 1101", fv); end
    checks++;
    if (fr[0] !== 7'd5) begin errors++; $display("FAIL same_fr0: got %0d expected 5", fr[0]); end
    checks++;
    if (fr[1] !== 7'd0) begin errors++; $display("FAIL same_fr1: got %0d expected 0", fr[1]); end
    checks++;
    if (fr[2] !== 7'd50) begin errors++; $display("FAIL same_fr2: got %0d expected 50", fr[2]); end
    checks++;
    if (fr[3] !== 7'd60) begin errors++; $display("FAIL same_fr3: got %0d expected 60", fr[3]); end
    read_check("same_table5", 5, 70);
  endtask

  task automatic test_dest_invalid();
    @(negedge clk); set_slot(1, 1, 0, 9, 99);
    step();
    checks++;
    if (fv !== 4'b0000) begin errors++; $display("FAIL dinv_fv: got %b expected 0000", fv); end
    checks++;
    if (fr[1] !== 7'd0) begin errors++; $display("FAIL dinv_fr1: got %0d expected 0", fr[1]); end
    read_check("dinv_table9", 9, 9);
  endtask

  task automatic test_distinct();
    @(negedge clk);
    set_slot(0, 1, 1, 1, 90);
    set_slot(1, 1, 1, 2, 91);
    set_slot(2, 1, 1, 4, 92);
    set_slot(3, 1, 1, 8, 93);
    step();
    checks++;
    if (fv !== 4'b1111) begin errors++; $display("FAIL dist_fv: got %b expected 1111", fv); end
    checks++;
    if (fr !== {7'd8, 7'd4, 7'd2, 7'd1})
      begin errors++; $display("FAIL dist_fr: got %0d %0d %0d %0d expected 1 2 4 8", fr[0], fr[1], fr[2], fr[3]); end
    read_check("dist_table1", 1, 90);
    read_check("dist_table2", 2, 91);
    read_check("dist_table4", 4, 92);
    read_check("dist_table8", 8, 93);
  endtask

  // Slot 0 is dest-valid but not retiring, so it must not shadow the table for slot 1.
  task automatic test_sparse_chain();
    @(negedge clk);
    set_slot(0, 0, 1, 1, 30);
    set_slot(1, 1, 1, 1, 20);
    set_slot(2, 1, 1, 0, 22);
    set_slot(3, 1, 1, 1, 21);
    step();
    checks++;
    if (fv !== 4'b1110) begin errors++; $display("FAIL chain_fv: got %b expected 1110", fv); end
    checks++;
    if (fr[1] !== 7'd90) begin errors++; $display("FAIL chain_fr1: got %0d expected 90", fr[1]); end
    checks++;
    if (fr[2] !== 7'd0) begin errors++; $display("FAIL chain_fr2: got %0d expected 0", fr[2]); end
    checks++;
    if (fr[3] !== 7'd20) begin errors++; $display("FAIL chain_fr3: got %0d expected 20", fr[3]); end
    read_check("chain_table1", 1, 21);
    read_check("chain_table0", 0, 22);
  endtask

  task automatic test_no_bypass();
    @(negedge clk); set_slot(0, 1, 1, 7, 33);
    read_check("nobyp_before", 7, 7);
    step();
    read_check("nobyp_after", 7, 33);
    checks++;
    if (fr[0] !== 7'd7) begin errors++; $display("FAIL nobyp_fr0: got %0d expected 7", fr[0]); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); set_slot(0, 1, 1, 10, 41);
    step();
    checks++;
    if (fv[0] !== 1'b1) begin errors++; $display("FAIL arst_pre_fv0: got %b expected 1", fv[0]); end
    set_slot(0, 1, 1, 6, 80);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (fv !== 4'b0000) begin errors++; $display("FAIL arst_fv: got %b expected 0000", fv); end
    checks++;
    if (fr[0] !== 7'd0) begin errors++; $display("FAIL arst_fr0: got %0d expected 0", fr[0]); end
    read_check("arst_table10", 10, 10);
    @(posedge clk); #1;
    checks++;
    if (fv !== 4'b0000) begin errors++; $display("FAIL arst_hold_fv: got %b expected 0000", fv); end
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;
    read_check("arst_table6", 6, 6);
    @(negedge clk); set_slot(0, 1, 1, 6, 81);
    step();
    checks++;
    if (fv !== 4'b0001 || fr[0] !== 7'd6)
      begin errors++; $display("FAIL arst_first_edge: got fv=%b fr0=%0d expected fv=0001 fr0=6", fv, fr[0]); end
    read_check("arst_table6_new", 6, 81);
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_dest();
    test_dest_invalid();
    test_distinct();
    test_sparse_chain();
    test_no_bypass();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
